// File: rtl/pwm_dac_pkg.sv
// Shared types and constants for the PWM DAC front end and the SAR search logic.
package pwm_dac_pkg;

  typedef enum logic [1:0] {
    SETTLED,
    PENDING,
    SETTLING
  } state_t;

  localparam int unsigned DEFAULT_WIDTH      = 8;
  localparam int unsigned DEFAULT_RESET_CODE = 127;
  localparam int unsigned SETTLE_CNT_W       = 4;

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter with boundary flag and registered end-of-period pulse.
module pwm_period_counter
  import pwm_dac_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] cnt,
  output logic             boundary,
  output logic             period_done
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             period_done_q, period_done_d;

  // Pulse is decoded one count early so the registered flag lines up with the boundary cycle.
  always_comb begin
    cnt_d         = cnt_q + WIDTH'(1);
    period_done_d = (cnt_q == ~WIDTH'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      period_done_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      period_done_q <= period_done_d;
    end
  end

  assign cnt         = cnt_q;
  assign boundary    = (cnt_q == '1);
  assign period_done = period_done_q;

endmodule

// File: rtl/pwm_dac.sv
// PWM DAC for the SAR ADC: shadow/duty registers, settle FSM and registered PWM output.
// Optional macro PWM_DAC_FULL_SCALE_EN makes the all-ones code drive a constant-high output.
module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int unsigned WIDTH          = DEFAULT_WIDTH,
  parameter int unsigned RESET_CODE     = DEFAULT_RESET_CODE,
  parameter int unsigned SETTLE_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] code,
  input  logic             load,
  output logic             pwm_out,
  output logic             period_done,
  output logic             settled
);

  localparam logic [WIDTH-1:0]        RESET_DUTY  = WIDTH'(RESET_CODE);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_PERIODS - 1);

  logic [WIDTH-1:0]        cnt;
  logic                    boundary;
  logic [WIDTH-1:0]        shadow_q, shadow_d;
  logic [WIDTH-1:0]        duty_q, duty_d;
  logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  state_t                  state_q, state_d;
  logic                    pwm_out_q, pwm_out_d;

  pwm_period_counter #(
    .WIDTH (WIDTH)
  ) u_period (
    .clk         (clk),
    .rst         (rst),
    .cnt         (cnt),
    .boundary    (boundary),
    .period_done (period_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q     <= RESET_DUTY;
      duty_q       <= RESET_DUTY;
      settle_cnt_q <= '0;
      state_q      <= SETTLING;
      pwm_out_q    <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      duty_q       <= duty_d;
      settle_cnt_q <= settle_cnt_d;
      state_q      <= state_d;
      pwm_out_q    <= pwm_out_d;
    end
  end

  // A load on the boundary cycle bypasses the shadow so the very next period uses the new code.
  always_comb begin
    shadow_d     = load ? code : shadow_q;
    duty_d       = duty_q;
    settle_cnt_d = settle_cnt_q;
    state_d      = state_q;
    if (boundary) begin
      duty_d = load ? code : shadow_q;
    end
    if (load) begin
      state_d      = boundary ? SETTLING : PENDING;
      settle_cnt_d = '0;
    end else begin
      case (state_q)
        SETTLED: state_d = SETTLED;
        PENDING: begin
          if (boundary) begin
            state_d      = SETTLING;
            settle_cnt_d = '0;
          end
        end
        SETTLING: begin
          if (boundary) begin
            if (settle_cnt_q == SETTLE_LAST) begin
              state_d = SETTLED;
            end else begin
              settle_cnt_d = settle_cnt_q + SETTLE_CNT_W'(1);
            end
          end
        end
        default: begin
          state_d      = SETTLING;
          settle_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    settled = (state_q == SETTLED);
`ifdef PWM_DAC_FULL_SCALE_EN
    pwm_out_d = (cnt < duty_q) || (duty_q == '1);
`else
    pwm_out_d = (cnt < duty_q);
`endif
  end

  assign pwm_out = pwm_out_q;

endmodule
